// File: rtl/fifo_drain_packer_pkg.sv
// Shared constants and helpers for the fifo drain packer.
// Latency: none (compile-time only).
// Backpressure: not applicable.
package fifo_drain_packer_pkg;

  // Legal range of words per output beat.
  localparam int PACK_MIN = 2;
  localparam int PACK_MAX = 16;

  // The skid buffer never shrinks below two entries.
  localparam int SKID_LOG_MIN = 1;

  // Width of a field able to hold 0..pack inclusive.
  function automatic int cnt_width(input int pack);
    return $clog2(pack + 1);
  endfunction

  // Skid depth exponent, clamped to the two-entry minimum.
  function automatic int skid_log(input int log2_skid);
    return (log2_skid < SKID_LOG_MIN) ? SKID_LOG_MIN : log2_skid;
  endfunction

endpackage

// File: rtl/fifo_drain_packer_if.sv
// Upstream fifo read port, flush handshake and packed output beat bundle.
// Latency: wires only.
// Backpressure: out_ready on the beat; skid reservation on the fifo side.
interface fifo_drain_packer_if #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
);
  import fifo_drain_packer_pkg::*;

  localparam int CW = cnt_width(PACK);

  logic                  fifo_empty;
  logic                  fifo_re;
  logic                  fifo_rvalid;
  logic [WIDTH-1:0]      fifo_rdata;
  logic                  flush;
  logic                  flush_done;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH*PACK-1:0] out_data;
  logic [CW-1:0]         out_count;
  logic [31:0]           perf_stall;
  logic [31:0]           perf_words;

  // Packer side.
  modport master (
    input  fifo_empty, fifo_rvalid, fifo_rdata, flush, out_ready,
    output fifo_re, flush_done, out_valid, out_data, out_count,
           perf_stall, perf_words
  );

  // Environment side: upstream fifo, flush source and beat consumer.
  modport slave (
    output fifo_empty, fifo_rvalid, fifo_rdata, flush, out_ready,
    input  fifo_re, flush_done, out_valid, out_data, out_count,
           perf_stall, perf_words
  );

endinterface

// File: rtl/fifo_drain_skid.sv
// First-word-fall-through skid buffer of 2**LOG2_SKID entries.
// Latency: a pushed word is visible at pop_data the following cycle.
// Backpressure: none internally; the caller reserves space before pushing.
module fifo_drain_skid #(
  parameter int WIDTH     = 8,
  parameter int LOG2_SKID = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   pop_data,
  output logic [LOG2_SKID:0] count,
  output logic               empty
);

  localparam int DEPTH = 1 << LOG2_SKID;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG2_SKID-1:0] wr_ptr;
  logic [LOG2_SKID-1:0] rd_ptr;

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH; push and pop together keep count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain_packer.sv
// Drains an upstream fifo and packs PACK words per beat; flush emits a partial beat.
// Latency: fifo_re to beat is rvalid + skid + one output register stage.
// Backpressure: out_ready low stalls the last word, fills the skid, then stops fifo_re.
// Optional: define FIFO_DRAIN_PERF_EN to build the stall/word performance counters.
module fifo_drain_packer
  import fifo_drain_packer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PACK      = 4,
  parameter int LOG2_SKID = 2
) (
  input logic                 clk,
  input logic                 reset,
  fifo_drain_packer_if.master bus
);

  localparam int SL    = skid_log(LOG2_SKID);
  localparam int DEPTH = 1 << SL;
  localparam int CW    = cnt_width(PACK);
  localparam int AW    = $clog2(PACK);

  if (PACK < PACK_MIN || PACK > PACK_MAX) begin : g_pack_range
    $error("fifo_drain_packer: PACK out of range");
  end

  logic                       re_q;
  logic                       flush_pend;
  logic [AW-1:0]              acc_cnt;
  logic [PACK-1:0][WIDTH-1:0] acc;
  logic [PACK-1:0][WIDTH-1:0] full_beat;
  logic [WIDTH-1:0]           skid_data;
  logic [SL:0]                skid_count;
  logic                       skid_empty;
  logic                       push;
  logic                       pop;
  logic                       out_free;
  logic                       last_slot;
  logic                       beat_full;
  logic                       flush_exec;
  logic                       flush_beat;

  // Data is only accepted for reads this block actually issued.
  assign push       = bus.fifo_rvalid && re_q;
  assign out_free   = !bus.out_valid || bus.out_ready;
  assign last_slot  = (acc_cnt == AW'(PACK - 1));
  // The final word of a beat waits in the skid until the output register frees.
  assign pop        = !skid_empty && (!last_slot || out_free);
  assign beat_full  = pop && last_slot;
  assign flush_exec = flush_pend && skid_empty && !re_q && out_free;
  assign flush_beat = flush_exec && (acc_cnt != '0);

  // An in-flight read holds a skid slot until its data does or does not arrive.
  assign bus.fifo_re = !bus.fifo_empty && !reset && !flush_pend &&
                       ((int'(skid_count) + int'(re_q)) < DEPTH);

  fifo_drain_skid #(.WIDTH(WIDTH), .LOG2_SKID(SL)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (bus.fifo_rdata),
    .pop       (pop),
    .pop_data  (skid_data),
    .count     (skid_count),
    .empty     (skid_empty)
  );

  // Complete beat: the accumulator with the word being popped in the top slot.
  always_comb begin
    full_beat           = acc;
    full_beat[PACK-1]   = skid_data;
  end

  // Read-in-flight tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) re_q <= 1'b0;
    else       re_q <= bus.fifo_re;
  end

  // Accumulator; cleared on every emission so a partial beat is zero-padded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (beat_full || flush_exec) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (pop) begin
      acc[acc_cnt] <= skid_data;
      acc_cnt      <= acc_cnt + AW'(1);
    end
  end

  // Output register; held stable while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_count <= '0;
    end else if (beat_full) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= full_beat;
      bus.out_count <= CW'(PACK);
    end else if (flush_beat) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= acc;
      bus.out_count <= CW'(acc_cnt);
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // Flush request latch; repeated requests merge into the pending one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pend     <= 1'b0;
      bus.flush_done <= 1'b0;
    end else begin
      bus.flush_done <= flush_exec;
      if (flush_exec)     flush_pend <= 1'b0;
      else if (bus.flush) flush_pend <= 1'b1;
    end
  end

`ifdef FIFO_DRAIN_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] words_q;

  // Free-running performance counters, wrapping at 2**32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      words_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(bus.out_valid && !bus.out_ready);
      words_q <= words_q + 32'(push);
    end
  end

  assign bus.perf_stall = stall_q;
  assign bus.perf_words = words_q;
`else
  assign bus.perf_stall = '0;
  assign bus.perf_words = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Self-checking bench: upstream fifo emulator, word-grouping beat model, per-cycle scoreboard.
// Latency: not applicable.
// Backpressure: random out_ready stalls exercised against the model.
module tb_fifo_drain_packer;

  localparam int WIDTH     = 8;
  localparam int PACK      = 4;
  localparam int LOG2_SKID = 2;

  logic clk = 1'b0;
  logic reset;

  fifo_drain_packer_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();

  fifo_drain_packer #(.WIDTH(WIDTH), .PACK(PACK), .LOG2_SKID(LOG2_SKID)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  pend_q[$];
  logic [31:0] exp_data[$];
  int          exp_cnt[$];
  logic [31:0] rx_data[$];
  int          rx_cnt[$];
  int          fd_exp = 0;
  int          fd_seen = 0;
  int          valid_seen = 0;
  int          words_pushed = 0;
  bit          gate_toggle = 0;
  bit          miss_en = 0;
  bit          junk_en = 0;
  bit          gate = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: words are grouped PACK at a time in arrival order.
  task automatic emit_pending();
    logic [31:0] d;
    d = '0;
    foreach (pend_q[i]) d[i*8 +: 8] = pend_q[i];
    exp_data.push_back(d);
    exp_cnt.push_back(pend_q.size());
    pend_q.delete();
  endtask

  task automatic model_push(input logic [7:0] w);
    src_q.push_back(w);
    pend_q.push_back(w);
    words_pushed++;
    if (pend_q.size() == PACK) emit_pending();
  endtask

  task automatic model_flush();
    if (pend_q.size() > 0) emit_pending();
    fd_exp++;
  endtask

  task automatic model_reset();
    src_q.delete();
    pend_q.delete();
    exp_data.delete();
    exp_cnt.delete();
    words_pushed = 0;
  endtask

  function automatic logic [31:0] rx_at(input int i);
    if (i >= 0 && i < rx_data.size()) return rx_data[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int rxc_at(input int i);
    if (i >= 0 && i < rx_cnt.size()) return rx_cnt[i];
    return -1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    model_reset();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    model_flush();
    cyc();
    bus.flush = 1'b0;
  endtask

  task automatic wait_src(input int budget, input string name);
    int n;
    n = 0;
    while (src_q.size() > 0 && n < budget) begin cyc(); n++; end
    check(name, 32'(src_q.size()), 32'd0);
  endtask

  task automatic wait_fd(input int budget, input string name);
    int n;
    n = 0;
    while (fd_seen != fd_exp && n < budget) begin cyc(); n++; end
    repeat (3) cyc();
    check(name, 32'(fd_seen), 32'(fd_exp));
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_data.size() > 0 || src_q.size() > 0) && n < budget) begin cyc(); n++; end
    check(name, 32'(exp_data.size()), 32'd0);
  endtask

  // Upstream fifo: data one cycle after a read, optional lost reads and stray rvalid.
  initial begin
    bit re_seen;
    bus.fifo_empty  = 1'b1;
    bus.fifo_rvalid = 1'b0;
    bus.fifo_rdata  = '0;
    forever begin
      @(negedge clk);
      re_seen = bus.fifo_re;
      @(posedge clk);
      #1;
      bus.fifo_rvalid = 1'b0;
      bus.fifo_rdata  = '0;
      if (re_seen && src_q.size() > 0 && !(miss_en && $urandom_range(0, 3) == 0)) begin
        bus.fifo_rvalid = 1'b1;
        bus.fifo_rdata  = src_q.pop_front();
      end else if (!re_seen && junk_en && $urandom_range(0, 3) == 0) begin
        bus.fifo_rvalid = 1'b1;
        bus.fifo_rdata  = 8'hEE;
      end
      gate = gate_toggle ? ~gate : 1'b0;
      bus.fifo_empty = (src_q.size() == 0) || gate;
    end
  end

  // Scoreboard: accepted beats against the model, stability while stalled.
  logic [31:0] held_data;
  int          held_cnt;
  bit          hold = 0;
  always @(negedge clk) begin
    if (reset) begin
      hold = 0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", bus.out_data, held_data);
        check("hold_count", 32'(bus.out_count), 32'(held_cnt));
      end
      if (bus.flush_done) fd_seen++;
      if (bus.out_valid) valid_seen++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h count %0d, none expected", bus.out_data, bus.out_count);
        end else begin
          check("beat_data", bus.out_data, exp_data.pop_front());
          check("beat_count", 32'(bus.out_count), 32'(exp_cnt.pop_front()));
        end
        rx_data.push_back(bus.out_data);
        rx_cnt.push_back(int'(bus.out_count));
      end
      hold      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      held_cnt  = int'(bus.out_count);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    int v0;
    int n;
    logic [31:0] exp_stall;
    logic [31:0] exp_words;
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) cyc();

    // Reset state.
    check("rst_fifo_re", 32'(bus.fifo_re), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flush_done", 32'(bus.flush_done), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_perf_stall", bus.perf_stall, 32'd0);
    check("rst_perf_words", bus.perf_words, 32'd0);
    reset = 1'b0;
    cyc();

    // Two full beats in order.
    r0 = rx_data.size();
    for (int w = 1; w <= 8; w++) model_push(8'(w));
    wait_drain(100, "t1_drain");
    check("t1_beats", 32'(rx_data.size() - r0), 32'd2);
    check("t1_beat0", rx_at(r0), 32'h0403_0201);
    check("t1_beat1", rx_at(r0 + 1), 32'h0807_0605);
    check("t1_cnt0", 32'(rxc_at(r0)), 32'd4);

    // Partial beat by flush.
    r0 = rx_data.size();
    model_push(8'hAA);
    model_push(8'hBB);
    wait_src(50, "t3_src");
    repeat (6) cyc();
    do_flush();
    wait_fd(40, "t3_flush_done");
    wait_drain(50, "t3_drain");
    check("t3_beat", rx_at(r0), 32'h0000_BBAA);
    check("t3_cnt", 32'(rxc_at(r0)), 32'd2);

    // Flush with nothing accumulated.
    v0 = valid_seen;
    do_flush();
    wait_fd(40, "t4_flush_done");
    repeat (4) cyc();
    check("t4_no_beat", 32'(valid_seen - v0), 32'd0);

    // Asynchronous reset with a partial accumulator.
    model_push(8'h21);
    model_push(8'h22);
    model_push(8'h23);
    wait_src(50, "t5_src");
    repeat (8) cyc();
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check("t5_out_data", bus.out_data, 32'd0);
    check("t5_out_count", 32'(bus.out_count), 32'd0);
    check("t5_fifo_re", 32'(bus.fifo_re), 32'd0);
    check("t5_flush_done", 32'(bus.flush_done), 32'd0);
    check("t5_perf_words", bus.perf_words, 32'd0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    r0 = rx_data.size();
    for (int w = 16; w <= 19; w++) model_push(8'(w));
    wait_drain(100, "t5_drain");
    check("t5_beat", rx_at(r0), 32'h1312_1110);
    check("t5_cnt", 32'(rxc_at(r0)), 32'd4);

    // Long stall: skid fills, fifo_re stops, nothing lost.
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 12; i++) model_push(8'($urandom_range(0, 255)));
    n = 0;
    while (!bus.out_valid && n < 50) begin cyc(); n++; end
    check("t2_first_valid", 32'(bus.out_valid), 32'd1);
    repeat (19) cyc();
`ifdef FIFO_DRAIN_PERF_EN
    exp_stall = 32'd19;
`else
    exp_stall = 32'd0;
`endif
    check("t2_perf_stall", bus.perf_stall, exp_stall);
    check("t2_fifo_re_stopped", 32'(bus.fifo_re), 32'd0);
    check("t2_words_left", 32'(src_q.size()), 32'd1);
    bus.out_ready = 1'b1;
    wait_drain(100, "t2_drain");

    // Random: gappy upstream, lost reads, stray rvalid, random backpressure.
    do_reset();
    gate_toggle = 1'b1;
    miss_en     = 1'b1;
    junk_en     = 1'b1;
    n = 0;
    for (int c = 0; c < 3000 && n < 62; c++) begin
      cyc();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        model_push(8'($urandom_range(0, 255)));
        n++;
      end
    end
    check("t6_all_pushed", 32'(n), 32'd62);
    bus.out_ready = 1'b1;
    wait_src(500, "t6_src");
    do_flush();
    wait_fd(100, "t6_flush_done");
    wait_drain(200, "t6_drain");
`ifdef FIFO_DRAIN_PERF_EN
    exp_words = 32'(words_pushed);
`else
    exp_words = 32'd0;
`endif
    check("t6_perf_words", bus.perf_words, exp_words);
    check("final_flush_done", 32'(fd_seen), 32'(fd_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_packer.md
FIFO_DRAIN_PACKER -- requirements
Module: fifo_drain_packer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of one word popped from the upstream fifo.
REQ-002 Parameter PACK, default 4: number of fifo words packed into one output beat, valid range 2..16.
REQ-003 Parameter LOG2_SKID, default 2: the skid buffer depth is 2**LOG2_SKID entries, with a minimum of 2 entries.
REQ-004 clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fifo_empty  in  1  upstream fifo empty flag.
REQ-007 fifo_re  out  1  upstream read request.
REQ-008 fifo_rvalid  in  1  upstream read data valid, arriving one cycle after fifo_re.
REQ-009 fifo_rdata  in  WIDTH  upstream read data.
REQ-010 flush  in  1  single-cycle pulse requesting emission of a partial beat.
REQ-011 flush_done  out  1  single-cycle pulse when a flush has completed.
REQ-012 out_valid  out  1  output beat valid.
REQ-013 out_ready  in  1  downstream accepts the beat.
REQ-014 out_data  out  WIDTH*PACK  packed beat, word 0 in the LSBs.
REQ-015 out_count  out  $clog2(PACK+1)  number of real words in the beat (PACK for a full beat).
REQ-016 perf_stall  out  32  cycles with out_valid=1 and out_ready=0.
REQ-017 perf_words  out  32  fifo words accepted.

Function
REQ-018 fifo_re SHALL be asserted only when all three hold: fifo_empty=0, no reset, and (skid_count + re_q) < 2**LOG2_SKID, where re_q is fifo_re registered one cycle.
REQ-019 A cycle with fifo_re=1 that returns no fifo_rvalid SHALL release its reserved skid slot on the next cycle; the block SHALL NOT hang.
REQ-020 fifo_rvalid SHALL write fifo_rdata into the skid buffer in the same cycle; fifo_rvalid arriving with re_q=0 SHALL be ignored.
REQ-021 The skid buffer SHALL be first-word-fall-through, with pointer wrap-around modulo 2**LOG2_SKID.
REQ-022 Simultaneous skid push and pop SHALL leave skid_count unchanged.
REQ-023 The packer SHALL pop at most one skid word per cycle, into accumulator slot acc_cnt (0..PACK-1).
REQ-024 When the PACK-th word is popped and the output register is free (out_valid=0, or out_ready=1), the accumulator plus that word SHALL load into out_data with out_count=PACK, out_valid=1 next cycle, and acc_cnt cleared in the same cycle.
REQ-025 If the output register is not free, the packer SHALL NOT pop the PACK-th word (stall); no data loss or duplication is permitted.
REQ-026 With out_ready held at 1, sustained throughput SHALL be one fifo word per cycle.
REQ-027 out_valid, out_data and out_count SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 flush SHALL set flush_pend, and a flush arriving while flush_pend=1 SHALL be absorbed.
REQ-029 flush_pend SHALL execute on the first cycle that has all of: skid empty, re_q=0, and output register free.
REQ-030 On flush execution with acc_cnt=k>0, the block SHALL load the accumulator zero-padded, out_count=k, and clear acc_cnt.
REQ-031 On flush execution with k=0, no beat SHALL be emitted.
REQ-032 Flush execution SHALL pulse flush_done for one cycle and clear flush_pend in both cases (k>0 and k=0).
REQ-033 While flush_pend=1, fifo_re SHALL be held at 0.
REQ-034 The perf counters SHALL wrap at 2**32.

Reset
REQ-035 While reset=1, fifo_re, out_valid, flush_done, out_count, acc_cnt, skid pointers/count, re_q, flush_pend and perf counters SHALL be 0; out_data SHALL be 0.
REQ-036 Reset mid-operation SHALL discard partial accumulator, skid contents and any pending flush with no output beat.

Configuration
REQ-037 With macro FIFO_DRAIN_PERF_EN defined, perf_stall and perf_words SHALL count as specified.
REQ-038 Without FIFO_DRAIN_PERF_EN, both ports SHALL remain present and tied to constant 0, and the counter flops SHALL be absent.

Structure
REQ-039 A shared package SHALL hold the PACK range-check constants and the out_count width function.
REQ-040 The skid buffer SHALL be one sub-module, fifo_drain_skid, parameterised by WIDTH and LOG2_SKID.

Verification (WIDTH=8, PACK=4, LOG2_SKID=2)
REQ-041 Stimulus: push 0x01..0x08 into the upstream fifo, out_ready=1. Required response: beats 0x04030201 then 0x08070605, each with out_count=4.
REQ-042 Stimulus: out_ready=0 for 20 cycles while 12 words are available. Required response: fifo_re stops once the skid is full; no word is lost; perf_stall=19 before release.
REQ-043 Stimulus: words 0xAA, 0xBB, then flush. Required response: beat 0x0000BBAA, out_count=2, then one flush_done pulse.
REQ-044 Stimulus: flush with an empty accumulator. Required response: flush_done pulses and out_valid stays 0.
REQ-045 Stimulus: reset asserted asynchronously after 3 words are accumulated. Required response: all outputs are 0 immediately; after release, words 0x10..0x13 give beat 0x13121110.
REQ-046 Stimulus: fifo_empty toggles every cycle with random out_ready. Required response: the output stream equals the input order, with perf_words equal to the number of words pushed.
